// File: rtl/msp_pkg.sv
// +----------------------------------------------------------------------+
// | msp_pkg : shared MSP v1 framing constants, status codes, FSM states  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package msp_pkg;

  localparam logic [7:0] MSP_SYNC     = 8'h24;
  localparam logic [7:0] MSP_M        = 8'h4D;
  localparam logic [7:0] MSP_DIR_REQ  = 8'h3C;
  localparam logic [7:0] MSP_DIR_RESP = 8'h3E;
  localparam logic [7:0] MSP_DIR_ERR  = 8'h21;

  typedef enum logic [1:0] {
    MSP_OK      = 2'd0,
    MSP_BAD     = 2'd1,
    MSP_TIMEOUT = 2'd2,
    MSP_NAK     = 2'd3
  } msp_status_t;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_TX_HDR  = 4'd1,
    ST_TX_LEN  = 4'd2,
    ST_TX_CMD  = 4'd3,
    ST_TX_PAY  = 4'd4,
    ST_TX_CK   = 4'd5,
    ST_RX_SYNC = 4'd6,
    ST_RX_M    = 4'd7,
    ST_RX_DIR  = 4'd8,
    ST_RX_LEN  = 4'd9,
    ST_RX_CMD  = 4'd10,
    ST_RX_PAY  = 4'd11,
    ST_RX_CK   = 4'd12,
    ST_DONE    = 4'd13
  } msp_req_state_t;

  function automatic logic [7:0] msp_clamp_len(input logic [7:0] len, input logic [7:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/msp_timeout_timer.sv
// +----------------------------------------------------------------------+
// | msp_timeout_timer : loadable down-counter with single-cycle expiry   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module msp_timeout_timer #(
  parameter int unsigned CYCLES = 72_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned W = $clog2(CYCLES + 1);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= W'(CYCLES);
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  // Fires on the cycle whose edge takes the count to zero; a reload wins.
  assign o_expired = i_en & ~i_load & (r_count == W'(1));

endmodule

`default_nettype wire

// File: rtl/msp_requester.sv
// +----------------------------------------------------------------------+
// | msp_requester : MSP v1 initiator, frames a $M< request and parses    |
// | the $M> / $M! reply, streaming reply payload and a final status.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module msp_requester
  import msp_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 72_000_000,
  parameter int unsigned MAX_PAYLOAD = 16,
  parameter int unsigned TIMEOUT_US  = 1000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [7:0]               req_cmd,
  input  logic [7:0]               req_len,
  input  logic [MAX_PAYLOAD*8-1:0] req_payload,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [7:0]               resp_data,
  output logic                     resp_valid,
  output logic                     done,
  output logic [1:0]               done_status,
  output logic [7:0]               done_len,
  output logic                     busy
);

  localparam int unsigned TIMEOUT_CYCLES = (CLK_FREQ_HZ / 1_000_000) * TIMEOUT_US;
  localparam logic [7:0]  MAX_LEN        = 8'(MAX_PAYLOAD);

  msp_req_state_t           r_state;
  logic [7:0]               r_cnt;
  logic [7:0]               r_cmd;
  logic [7:0]               r_len;
  logic [7:0]               r_ck;
  logic [MAX_PAYLOAD*8-1:0] r_payload;
  logic [7:0]               r_rx_len;
  logic [7:0]               r_rx_cmd;
  logic [7:0]               r_rx_ck;
  logic                     r_nak;
  logic [7:0]               r_resp_data;
  logic                     r_resp_valid;
  msp_status_t              r_done_status;
  logic [7:0]               r_done_len;

  logic [7:0] w_tx_data;
  logic [7:0] w_clamped_len;
  logic       w_tx_valid;
  logic       w_tx_fire;
  logic       w_rx_active;
  logic       w_timer_load;
  logic       w_expired;

  assign w_clamped_len = msp_clamp_len(req_len, MAX_LEN);
  assign w_tx_valid    = r_state inside {ST_TX_HDR, ST_TX_LEN, ST_TX_CMD, ST_TX_PAY, ST_TX_CK};
  assign w_tx_fire     = w_tx_valid & tx_ready;
  assign w_rx_active   = r_state inside {ST_RX_SYNC, ST_RX_M, ST_RX_DIR, ST_RX_LEN,
                                         ST_RX_CMD, ST_RX_PAY, ST_RX_CK};
  // Arm on the final request byte, then re-arm on every received byte.
  assign w_timer_load  = ((r_state == ST_TX_CK) & w_tx_fire) | (w_rx_active & rx_valid);

  msp_timeout_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_timer_load),
    .i_en      (w_rx_active),
    .o_expired (w_expired)
  );

  always_comb begin
    w_tx_data = 8'h00;
    case (r_state)
      ST_TX_HDR: w_tx_data = (r_cnt == 8'd0) ? MSP_SYNC :
                             (r_cnt == 8'd1) ? MSP_M : MSP_DIR_REQ;
      ST_TX_LEN: w_tx_data = r_len;
      ST_TX_CMD: w_tx_data = r_cmd;
      ST_TX_PAY: w_tx_data = r_payload[7:0];
      ST_TX_CK:  w_tx_data = r_ck;
      default:   w_tx_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= 8'h00;
      r_cmd         <= 8'h00;
      r_len         <= 8'h00;
      r_ck          <= 8'h00;
      r_payload     <= '0;
      r_rx_len      <= 8'h00;
      r_rx_cmd      <= 8'h00;
      r_rx_ck       <= 8'h00;
      r_nak         <= 1'b0;
      r_resp_data   <= 8'h00;
      r_resp_valid  <= 1'b0;
      r_done_status <= MSP_OK;
      r_done_len    <= 8'h00;
    end else begin
      r_resp_valid <= 1'b0;
      if (w_rx_active && w_expired) begin
        r_state       <= ST_DONE;
        r_done_status <= MSP_TIMEOUT;
        r_done_len    <= 8'h00;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (req_valid) begin
              r_cmd     <= req_cmd;
              r_len     <= w_clamped_len;
              r_payload <= req_payload;
              r_ck      <= w_clamped_len ^ req_cmd;
              r_cnt     <= 8'h00;
              r_state   <= ST_TX_HDR;
            end
          end
          ST_TX_HDR: begin
            if (w_tx_fire) begin
              if (r_cnt == 8'd2) begin
                r_cnt   <= 8'h00;
                r_state <= ST_TX_LEN;
              end else begin
                r_cnt <= r_cnt + 8'd1;
              end
            end
          end
          ST_TX_LEN: if (w_tx_fire) r_state <= ST_TX_CMD;
          ST_TX_CMD: begin
            if (w_tx_fire) begin
              r_cnt   <= r_len;
              r_state <= (r_len == 8'h00) ? ST_TX_CK : ST_TX_PAY;
            end
          end
          ST_TX_PAY: begin
            // Payload drains from the low byte so tx_data is always bits [7:0].
            if (w_tx_fire) begin
              r_ck      <= r_ck ^ r_payload[7:0];
              r_payload <= r_payload >> 8;
              r_cnt     <= r_cnt - 8'd1;
              if (r_cnt == 8'd1) r_state <= ST_TX_CK;
            end
          end
          ST_TX_CK: if (w_tx_fire) r_state <= ST_RX_SYNC;
          ST_RX_SYNC: if (rx_valid && rx_data == MSP_SYNC) r_state <= ST_RX_M;
          ST_RX_M: begin
            if (rx_valid) begin
              if (rx_data == MSP_M)         r_state <= ST_RX_DIR;
              else if (rx_data != MSP_SYNC) r_state <= ST_RX_SYNC;
            end
          end
          ST_RX_DIR: begin
            if (rx_valid) begin
              if (rx_data == MSP_DIR_RESP || rx_data == MSP_DIR_ERR) begin
                r_nak   <= (rx_data == MSP_DIR_ERR);
                r_state <= ST_RX_LEN;
              end else begin
                r_state <= ST_RX_SYNC;
              end
            end
          end
          ST_RX_LEN: begin
            if (rx_valid) begin
              r_rx_len <= rx_data;
              r_rx_ck  <= rx_data;
              r_state  <= ST_RX_CMD;
            end
          end
          ST_RX_CMD: begin
            if (rx_valid) begin
              r_rx_cmd <= rx_data;
              r_rx_ck  <= r_rx_ck ^ rx_data;
              r_cnt    <= r_rx_len;
              r_state  <= (r_rx_len == 8'h00) ? ST_RX_CK : ST_RX_PAY;
            end
          end
          ST_RX_PAY: begin
            if (rx_valid) begin
              r_resp_data  <= rx_data;
              r_resp_valid <= 1'b1;
              r_rx_ck      <= r_rx_ck ^ rx_data;
              r_cnt        <= r_cnt - 8'd1;
              if (r_cnt == 8'd1) r_state <= ST_RX_CK;
            end
          end
          ST_RX_CK: begin
            if (rx_valid) begin
              r_done_len <= r_rx_len;
              if (rx_data != r_rx_ck || r_rx_cmd != r_cmd) r_done_status <= MSP_BAD;
              else if (r_nak)                              r_done_status <= MSP_NAK;
              else                                         r_done_status <= MSP_OK;
              r_state <= ST_DONE;
            end
          end
          ST_DONE: r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign req_ready   = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign tx_data     = w_tx_data;
  assign tx_valid    = w_tx_valid;
  assign resp_data   = r_resp_data;
  assign resp_valid  = r_resp_valid;
  assign done        = (r_state == ST_DONE);
  assign done_status = r_done_status;
  assign done_len    = r_done_len;

endmodule

`default_nettype wire

// File: tb/tb_msp_requester.sv
// +----------------------------------------------------------------------+
// | tb_msp_requester : directed, model-checked bench for msp_requester   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_msp_requester;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [7:0]   req_cmd;
  logic [7:0]   req_len;
  logic [127:0] req_payload;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [7:0]   resp_data;
  logic         resp_valid;
  logic         done;
  logic [1:0]   done_status;
  logic [7:0]   done_len;
  logic         busy;

  always #5 clk = ~clk;

  msp_requester #(
    .CLK_FREQ_HZ (1_000_000),
    .MAX_PAYLOAD (16),
    .TIMEOUT_US  (50)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_cmd     (req_cmd),
    .req_len     (req_len),
    .req_payload (req_payload),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .resp_data   (resp_data),
    .resp_valid  (resp_valid),
    .done        (done),
    .done_status (done_status),
    .done_len    (done_len),
    .busy        (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_resp[$];
  logic [1:0] exp_status;
  logic [7:0] exp_len;
  logic [7:0] rq[$];
  logic [7:0] lit[$];
  logic [7:0] cap_tx[$];
  logic [7:0] cap_resp[$];
  int         done_cnt = 0;
  int         tx_cycles = 0;
  int         last_act = 0;
  logic [1:0] last_status;
  logic [7:0] last_len;
  logic       prev_txv, prev_txr, prev_rxv, tx_active;
  logic [7:0] prev_txd;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected request frame: header, clamped length, cmd, payload, XOR checksum.
  task automatic model_tx(input logic [7:0] cmd, input logic [7:0] len, input logic [127:0] pay);
    int n;
    logic [7:0] ck, b;
    n = (len > 8'd16) ? 16 : int'(len);
    exp_tx.delete();
    exp_tx.push_back(8'h24); exp_tx.push_back(8'h4D); exp_tx.push_back(8'h3C);
    exp_tx.push_back(8'(n)); exp_tx.push_back(cmd);
    ck = 8'(n) ^ cmd;
    for (int k = 0; k < n; k++) begin
      b = pay[k*8 +: 8];
      exp_tx.push_back(b);
      ck ^= b;
    end
    exp_tx.push_back(ck);
  endtask

  // Expected reply outcome from the byte stream in rq; an incomplete frame times out.
  task automatic model_rx(input logic [7:0] cmd);
    int i, n;
    bit found, nak;
    logic [7:0] len, rcmd, ck;
    exp_resp.delete();
    exp_status = 2'd2;
    exp_len    = 8'd0;
    n = rq.size(); i = 0; found = 0; nak = 0;
    while (!found && i < n) begin
      if (rq[i] != 8'h24) begin i++; continue; end
      i++;
      while (i < n && rq[i] == 8'h24) i++;
      if (i >= n) break;
      if (rq[i] != 8'h4D) begin i++; continue; end
      i++;
      if (i >= n) break;
      if (rq[i] == 8'h3E || rq[i] == 8'h21) begin
        nak = (rq[i] == 8'h21);
        found = 1;
      end
      i++;
    end
    if (!found || i >= n) return;
    len = rq[i]; ck = len; i++;
    if (i >= n) return;
    rcmd = rq[i]; ck ^= rcmd; i++;
    for (int k = 0; k < int'(len); k++) begin
      if (i >= n) return;
      exp_resp.push_back(rq[i]);
      ck ^= rq[i];
      i++;
    end
    if (i >= n) return;
    exp_status = (rq[i] != ck || rcmd != cmd) ? 2'd1 : (nak ? 2'd3 : 2'd0);
    exp_len    = len;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_txv  <= 1'b0;
      prev_txr  <= 1'b0;
      prev_rxv  <= 1'b0;
      prev_txd  <= 8'h00;
      tx_active <= 1'b0;
    end else begin
      if (prev_txv && !prev_txr) begin
        chk("tx_hold_valid", tx_valid, 1);
        chk("tx_hold_data", tx_data, prev_txd);
      end
      if (tx_active && !tx_valid) chk("tx_drop", tx_valid, 1);
      if (tx_valid) begin
        tx_cycles++;
        tx_active <= 1'b1;
      end
      if (tx_valid && tx_ready) begin
        cap_tx.push_back(tx_data);
        last_act = cyc + 1;
        if (exp_tx.size() == 0) chk("tx_extra", tx_data, 8'hxx);
        else chk("tx_byte", tx_data, exp_tx.pop_front());
        if (exp_tx.size() == 0) tx_active <= 1'b0;
      end
      if (rx_valid) last_act = cyc + 1;
      if (resp_valid) begin
        cap_resp.push_back(resp_data);
        chk("resp_lat", prev_rxv, 1);
        if (exp_resp.size() == 0) chk("resp_extra", resp_data, 8'hxx);
        else chk("resp_byte", resp_data, exp_resp.pop_front());
      end
      if (done) begin
        done_cnt++;
        last_status = done_status;
        last_len    = done_len;
        chk("done_status", done_status, exp_status);
        chk("done_len", done_len, exp_len);
        chk("resp_left", exp_resp.size(), 0);
        if (exp_status == 2'd2) chk("timeout_gap", cyc - last_act, 50);
        else                    chk("done_lat", prev_rxv, 1);
      end
      prev_txv <= tx_valid;
      prev_txr <= tx_ready;
      prev_txd <= tx_data;
      prev_rxv <= rx_valid;
    end
  end

  task automatic start_req(input logic [7:0] cmd, input logic [7:0] len,
                           input logic [127:0] pay, input bit stall);
    bit ok;
    model_tx(cmd, len, pay);
    model_rx(cmd);
    cap_tx.delete(); cap_resp.delete(); tx_cycles = 0;
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      if (req_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    chk("req_ready_wait", ok, 1);
    tx_ready = !stall;
    req_valid = 1'b1; req_cmd = cmd; req_len = len; req_payload = pay;
    @(posedge clk); #1;
    chk("busy_after_accept", busy, 1);
    // While busy, a competing request is offered and must be ignored.
    req_valid = stall; req_cmd = 8'h55; req_len = 8'd5; req_payload = '1;
    for (int k = 0; k < 300 && exp_tx.size() != 0; k++) begin
      tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
    end
    chk("tx_complete", exp_tx.size(), 0);
    req_valid = 1'b0; tx_ready = 1'b0;
  endtask

  task automatic feed(input int nbytes);
    for (int k = 0; k < nbytes; k++) begin
      rx_valid = 1'b1; rx_data = rq[k];
      @(posedge clk); #1;
      rx_valid = 1'b0; rx_data = 8'h00;
    end
  endtask

  task automatic run_txn(input logic [7:0] cmd, input logic [7:0] len,
                         input logic [127:0] pay, input bit stall);
    int d0;
    d0 = done_cnt;
    start_req(cmd, len, pay, stall);
    feed(rq.size());
    for (int k = 0; k < 200 && done_cnt == d0; k++) begin
      @(posedge clk); #1;
    end
    chk("done_seen", done_cnt - d0, 1);
  endtask

  task automatic check_lit_tx();
    chk("tx_lit_len", cap_tx.size(), lit.size());
    for (int k = 0; k < lit.size(); k++)
      if (k < cap_tx.size()) chk("tx_lit", cap_tx[k], lit[k]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst_n = 1'b0; req_valid = 1'b0; req_cmd = 8'h00; req_len = 8'h00; req_payload = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_done", done, 0);
    chk("rst_done_status", done_status, 0);
    chk("rst_done_len", done_len, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic OK reply, len 0 request.
    rq = {8'h24, 8'h4D, 8'h3E, 8'h03, 8'h01, 8'h00, 8'h01, 8'h02, 8'h01};
    run_txn(8'h01, 8'h00, 128'h0, 1'b0);
    lit = {8'h24, 8'h4D, 8'h3C, 8'h00, 8'h01, 8'h01};
    check_lit_tx();
    chk("t1_tx_cycles", tx_cycles, 6);
    chk("t1_status", last_status, 0);
    chk("t1_len", last_len, 3);
    chk("t1_resp_n", cap_resp.size(), 3);
    if (cap_resp.size() == 3) begin
      chk("t1_resp0", cap_resp[0], 8'h00);
      chk("t1_resp1", cap_resp[1], 8'h01);
      chk("t1_resp2", cap_resp[2], 8'h02);
    end

    // Backpressured transmit with a payload.
    rq = {8'h24, 8'h4D, 8'h3E, 8'h00, 8'hC8, 8'hC8};
    run_txn(8'hC8, 8'h02, 128'h2211, 1'b1);
    lit = {8'h24, 8'h4D, 8'h3C, 8'h02, 8'hC8, 8'h11, 8'h22, 8'hF9};
    check_lit_tx();
    chk("t2_status", last_status, 0);

    rq = {8'h24, 8'h4D, 8'h3E, 8'h03, 8'h01, 8'h00, 8'h01, 8'h02, 8'h00};
    run_txn(8'h01, 8'h00, 128'h0, 1'b0);
    chk("t3_bad_ck", last_status, 1);
    chk("t3_len", last_len, 3);

    rq = {8'h24, 8'h4D, 8'h3E, 8'h00, 8'h02, 8'h02};
    run_txn(8'h01, 8'h00, 128'h0, 1'b0);
    chk("t4_bad_cmd", last_status, 1);

    rq = {8'h24, 8'h4D, 8'h21, 8'h00, 8'h01, 8'h01};
    run_txn(8'h01, 8'h00, 128'h0, 1'b0);
    chk("t5_nak", last_status, 3);
    chk("t5_len", last_len, 0);

    rq.delete();
    run_txn(8'h01, 8'h00, 128'h0, 1'b0);
    chk("t6_timeout", last_status, 2);
    chk("t6_len", last_len, 0);

    rq = {8'h24, 8'h4D, 8'h3E, 8'h03};
    run_txn(8'h01, 8'h00, 128'h0, 1'b0);
    chk("t7_timeout", last_status, 2);
    chk("t7_len", last_len, 0);
    chk("t7_resp_n", cap_resp.size(), 0);

    rq = {8'h00, 8'h24, 8'h24, 8'h4D, 8'h3E, 8'h01, 8'h01, 8'hAA, 8'hAA};
    run_txn(8'h01, 8'h00, 128'h0, 1'b0);
    chk("t8_status", last_status, 0);
    chk("t8_len", last_len, 1);
    chk("t8_resp_n", cap_resp.size(), 1);
    if (cap_resp.size() == 1) chk("t8_resp0", cap_resp[0], 8'hAA);

    // Oversized length clamps to 16 payload bytes.
    rq = {8'h24, 8'h4D, 8'h3E, 8'h00, 8'h09, 8'h09};
    run_txn(8'h09, 8'd20, 128'h100f0e0d0c0b0a090807060504030201, 1'b0);
    chk("t9_tx_cycles", tx_cycles, 22);
    if (cap_tx.size() > 3) chk("t9_len_byte", cap_tx[3], 8'h10);
    chk("t9_status", last_status, 0);

    // Reset in the middle of the reply payload.
    rq = {8'h24, 8'h4D, 8'h3E, 8'h05, 8'h07, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h12};
    d0 = done_cnt;
    start_req(8'h07, 8'h00, 128'h0, 1'b0);
    feed(8);
    rst_n = 1'b0;
    #1;
    chk("t10_resp_seen", exp_resp.size(), 3);
    chk("t10_req_ready", req_ready, 1);
    chk("t10_busy", busy, 0);
    chk("t10_resp_valid", resp_valid, 0);
    chk("t10_tx_valid", tx_valid, 0);
    chk("t10_done", done, 0);
    chk("t10_done_len", done_len, 0);
    exp_resp.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    chk("t10_no_done", done_cnt - d0, 0);

    rq = {8'h24, 8'h4D, 8'h3E, 8'h03, 8'h01, 8'h00, 8'h01, 8'h02, 8'h01};
    run_txn(8'h01, 8'h00, 128'h0, 1'b0);
    chk("t11_status", last_status, 0);
    chk("t11_len", last_len, 3);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/msp_requester.md
# msp_requester

MSP v1 initiator: accepts a command with an optional payload from local logic, frames and transmits it as an `$M<` request, then parses the matching `$M>` or `$M!` reply. Reply payload bytes are streamed out as they arrive, followed by a completion status. It is the link-side counterpart of the MSP responder. It sits between a control/sequencer block and a byte-level UART/SPI link.

## Interface
Parameters:
- `CLK_FREQ_HZ`, 72_000_000, clock frequency used to derive the timeout.
- `MAX_PAYLOAD`, 16, maximum request payload bytes.
- `TIMEOUT_US`, 1000, reply inactivity timeout. Expressed as `TIMEOUT_CYCLES = (CLK_FREQ_HZ/1_000_000)*TIMEOUT_US`.

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request offered.
- `req_ready`  out  1  high only in IDLE.
- `req_cmd`  in  8  MSP command id.
- `req_len`  in  8  request payload length; values above MAX_PAYLOAD are clamped.
- `req_payload`  in  MAX_PAYLOAD*8  payload; byte i at bits [8i+7:8i]. Captured on accept.
- `tx_data`  out  8  byte to link.
- `tx_valid`  out  1  byte is valid.
- `tx_ready`  in  1  link accepts the byte.
- `rx_data`  in  8  byte from link.
- `rx_valid`  in  1  one-cycle strobe; there is no backpressure.
- `resp_data`  out  8  reply payload byte.
- `resp_valid`  out  1  one-cycle strobe per reply payload byte.
- `done`  out  1  one-cycle pulse at transaction end.
- `done_status`  out  2  0=OK, 1=BAD (checksum or cmd mismatch), 2=TIMEOUT, 3=NAK (`!` direction).
- `done_len`  out  8  reply length field; 0 on TIMEOUT.
- `busy`  out  1  high from accept until `done`.

## Operation
- States: IDLE, TX_HDR (3 bytes), TX_LEN, TX_CMD, TX_PAY, TX_CK, RX_SYNC, RX_M, RX_DIR, RX_LEN, RX_CMD, RX_PAY, RX_CK, DONE.
- On accept, capture cmd, the clamped len, and the payload. Transmit `24 4D 3C len cmd payload[0..len-1] ck`.
  - `ck` = XOR of len, cmd, and all payload bytes (8-bit).
- TX_CK completes on handshake and goes to RX_SYNC. The timeout counter loads TIMEOUT_CYCLES there.
- RX parsing:
  - RX_SYNC: only `24` advances; everything else is dropped.
  - RX_M: `4D` advances; `24` stays in RX_M; any other byte returns to RX_SYNC.
  - RX_DIR: `3E` means normal reply, `21` means NAK. Both continue parsing. Any other byte returns to RX_SYNC.
- RX_LEN and RX_CMD seed the running XOR.
- RX_PAY emits every byte on `resp_data`/`resp_valid`; there is no length limit on reply bytes. len=0 skips RX_PAY.
- RX_CK result:
  - checksum mismatch or reply cmd ≠ request cmd → BAD;
  - otherwise NAK if direction was `!`;
  - otherwise OK.
- Consumers discard streamed bytes unless status is OK.
- Timeout:
  - The counter decrements every cycle in the RX states and reloads on each `rx_valid`.
  - Reaching zero goes to DONE with TIMEOUT, including mid-frame.
- DONE lasts one cycle: `done`=1, then IDLE.
- `rx_valid` outside the RX states is ignored.

## Timing
- Reset values: `req_ready`=1 (IDLE). All other outputs are 0.
- Accept at edge N → `tx_valid`=1 with `tx_data`=`24` after edge N.
- A byte advances only on `tx_valid && tx_ready`. `tx_data` holds stable while stalled. `tx_valid` never drops mid-frame.
- With `tx_ready` tied high, a request occupies 6+len consecutive cycles.
- `resp_valid` asserts the cycle after the sampled `rx_valid` (1-cycle latency).
- `done` asserts the cycle after the checksum byte is sampled. `done_status` and `done_len` are valid only while `done`=1.
- `req_valid` while busy is not accepted and does not affect the transaction in flight.
- `rst_n` low at any point aborts immediately; no `done` is emitted.

## Structure
- Package `msp_pkg` holds:
  - constants `MSP_SYNC`=8'h24, `MSP_M`=8'h4D, `MSP_DIR_REQ`=8'h3C, `MSP_DIR_RESP`=8'h3E, `MSP_DIR_ERR`=8'h21;
  - enum `msp_status_t`;
  - the requester state enum.
- One sub-module, `msp_timeout_timer`: loadable down-counter with a reload strobe and an expiry pulse, sized by `$clog2(TIMEOUT_CYCLES+1)`.

## Test plan
- Request cmd=1, len=0 → tx `24 4D 3C 00 01 01`. Feed `24 4D 3E 03 01 00 01 02 01` → resp bytes `00 01 02`, `done` with OK, `done_len`=3.
- cmd=200 (`C8`), len=2, payload `11 22`, `tx_ready` toggling randomly → tx exactly `24 4D 3C 02 C8 11 22 F9`, with no drops or duplicates and `tx_data` stable during stalls.
- Reply checksum byte corrupted (`00` in place of `01`) → status BAD. Reply with cmd `02` to a cmd-1 request → status BAD.
- Reply `24 4D 21 00 01 01` → NAK, `done_len`=0.
- With CLK_FREQ_HZ=1_000_000, TIMEOUT_US=50 and no reply → `done` with TIMEOUT 50 cycles after the last tx handshake. The same occurs when the reply stops after its len byte.
- Garbage prefix `00 24 24 4D 3E …` → parsed OK. Assert `rst_n` mid-RX_PAY → all outputs reset, `req_ready`=1, and a subsequent request works.
